// File: rtl/weight_sram_sched.sv
// Single-port scheduler for the weight SRAM: interleaves loader writes with
// PE-array burst reads, times the read-path OE and flags out-of-range words.
module weight_sram_sched #(
    parameter int DEPTH   = 196608,
    parameter int MAX_LEN = 256
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        wr_valid,
    input  logic [17:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        wr_ready,
    input  logic        rd_start,
    input  logic [17:0] rd_base,
    input  logic [8:0]  rd_len,
    output logic        rd_busy,
    output logic [15:0] rd_data,
    output logic        rd_data_valid,
    output logic        rd_last,
    output logic        rd_done,
    output logic        addr_err,
    input  logic        err_clr,
    output logic        mem_cs,
    output logic        mem_oe,
    output logic        mem_web,
    output logic [17:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    typedef enum logic {IDLE, RD} state_t;

    localparam logic [18:0] DEPTH_W   = 19'(DEPTH);
    localparam logic [9:0]  MAX_LEN_W = 10'(MAX_LEN);

    state_t      state, state_nxt;
    logic [17:0] rd_addr;
    logic [8:0]  rd_remaining;
    logic        prefer_wr;
    logic        p1_valid, p1_err, p1_last, oe_q;
    logic [17:0] mem_addr_q;
    logic [15:0] mem_wdata_q;
    logic        grant_wr, grant_rd;
    logic        wr_oor, rd_oor, last_beat, start_ok, err_set;

    assign wr_oor    = {1'b0, wr_addr} >= DEPTH_W;
    assign rd_oor    = {1'b0, rd_addr} >= DEPTH_W;
    assign last_beat = rd_remaining == 9'd1;

    // Busy covers the read pipeline tail so a new start waits for rd_done.
    assign rd_busy  = (state == RD) || p1_valid || rd_data_valid;
    assign start_ok = rd_start && !rd_busy && (rd_len != 9'd0)
                      && ({1'b0, rd_len} <= MAX_LEN_W);
    assign err_set  = (grant_wr && wr_oor) || (grant_rd && rd_oor);
    assign mem_oe   = oe_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_ok) state_nxt = RD;
            RD:   if (grant_rd && last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grants are gated by rstn so the SRAM port is quiet while reset is held.
    always_comb begin
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        if (rstn) begin
            if (state == RD) begin
                grant_wr = wr_valid && prefer_wr;
                grant_rd = !grant_wr;
            end else begin
                grant_wr = wr_valid;
            end
        end
        wr_ready  = grant_wr;
        mem_cs    = (grant_wr && !wr_oor) || (grant_rd && !rd_oor);
        mem_web   = !(grant_wr && !wr_oor);
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        if (grant_wr) begin
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end else if (grant_rd) begin
            mem_addr  = rd_addr;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_addr       <= '0;
            rd_remaining  <= '0;
            prefer_wr     <= 1'b1;
            p1_valid      <= 1'b0;
            p1_err        <= 1'b0;
            p1_last       <= 1'b0;
            oe_q          <= 1'b0;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
            rd_last       <= 1'b0;
            rd_done       <= 1'b0;
            addr_err      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            if (start_ok) begin
                rd_addr      <= rd_base;
                rd_remaining <= rd_len;
            end else if (grant_rd) begin
                rd_addr      <= rd_addr + 18'd1;
                rd_remaining <= rd_remaining - 9'd1;
            end
            // The pointer only moves on contended cycles, giving W,R,W,R.
            if (state == RD && wr_valid) prefer_wr <= !prefer_wr;
            p1_valid      <= grant_rd;
            p1_err        <= grant_rd && rd_oor;
            p1_last       <= grant_rd && last_beat;
            oe_q          <= grant_rd && !rd_oor;
            rd_data_valid <= p1_valid;
            rd_last       <= p1_last;
            rd_done       <= p1_last;
            if (p1_valid) rd_data <= p1_err ? 16'd0 : mem_rdata;
            if (err_set)      addr_err <= 1'b1;
            else if (err_clr) addr_err <= 1'b0;
            if (grant_wr) begin
                mem_addr_q  <= wr_addr;
                mem_wdata_q <= wr_data;
            end else if (grant_rd) begin
                mem_addr_q  <= rd_addr;
            end
        end
    end

endmodule

// File: tb/tb_weight_sram_sched.sv
// Randomised bench for weight_sram_sched: a behavioural SRAM plus a
// transaction-level model of grants, beat timing and read data.
module tb_weight_sram_sched;

    localparam int DEPTH = 196608;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wr_valid, wr_ready, rd_start, rd_busy, rd_data_valid, rd_last, rd_done;
    logic        addr_err, err_clr, mem_cs, mem_oe, mem_web;
    logic [17:0] wr_addr, rd_base, mem_addr;
    logic [15:0] wr_data, rd_data, mem_wdata, mem_rdata;
    logic [8:0]  rd_len;

    int checks = 0;
    int failures = 0;

    logic [15:0] sram [0:DEPTH-1];
    logic [15:0] sram_q;
    logic [15:0] ref_mem [int];
    bit          model_prefer_wr;

    int          wq_addr[$];
    logic [15:0] wq_data[$];

    string       exp_trace, exp_busy, obs_trace, obs_busy;
    int          exp_oe[$], exp_valid[$], obs_oe[$], obs_valid[$], obs_last[$], obs_done[$];
    logic [15:0] exp_data[$], obs_data[$];
    int          exp_end;

    logic        w_ready, w_cs, w_web, w_err;
    logic [17:0] w_addr;
    logic [15:0] w_wdata;

    always #5 clk = ~clk;

    weight_sram_sched #(.DEPTH(DEPTH), .MAX_LEN(256)) dut (
        .clk(clk), .rstn(rstn),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len), .rd_busy(rd_busy),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_last(rd_last), .rd_done(rd_done),
        .addr_err(addr_err), .err_clr(err_clr),
        .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_web(mem_web),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_cs && ({14'd0, mem_addr} < DEPTH)) begin
            if (!mem_web) sram[mem_addr] <= mem_wdata;
            else          sram_q <= sram[mem_addr];
        end
    end
    assign mem_rdata = sram_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_read(int a);
        if (a >= DEPTH) return 16'd0;
        if (ref_mem.exists(a)) return ref_mem[a];
        return 16'd0;
    endfunction

    task automatic do_write(int a, logic [15:0] d, logic clr);
        tick();
        wr_valid = 1'b1;
        wr_addr  = 18'(a);
        wr_data  = d;
        err_clr  = clr;
        #1;
        w_ready = wr_ready;
        w_cs    = mem_cs;
        w_web   = mem_web;
        w_addr  = mem_addr;
        w_wdata = mem_wdata;
        tick();
        wr_valid = 1'b0;
        err_clr  = 1'b0;
        #1;
        w_err = addr_err;
        if (a < DEPTH) ref_mem[a] = d;
    endtask

    // Schedule derived from the arbitration rules: reads from cycle 1,
    // writes contend round-robin, data two cycles after each read issue.
    task automatic build_expected(int base, int len);
        int pw, pr, widx, ridx, last_issue, k, a;
        bit do_w;
        pw = wq_addr.size(); pr = len; widx = 0; ridx = 0; last_issue = 0; k = 1;
        exp_trace = ".";
        exp_oe.delete(); exp_valid.delete(); exp_data.delete();
        while (pr > 0 || pw > 0) begin
            if (pr > 0 && pw > 0) begin
                do_w = model_prefer_wr;
                model_prefer_wr = !model_prefer_wr;
            end else begin
                do_w = (pw > 0);
            end
            if (do_w) begin
                a = wq_addr[widx];
                if (a < DEPTH) begin exp_trace = {exp_trace, "W"}; ref_mem[a] = wq_data[widx]; end
                else           exp_trace = {exp_trace, "w"};
                widx++; pw--;
            end else begin
                a = (base + ridx) % 262144;
                if (a < DEPTH) begin exp_trace = {exp_trace, "R"}; exp_oe.push_back(k + 1); end
                else           exp_trace = {exp_trace, "."};
                exp_valid.push_back(k + 2);
                exp_data.push_back(ref_read(a));
                ridx++; pr--; last_issue = k;
            end
            k++;
        end
        exp_end = last_issue + 3;
        while (exp_trace.len() < exp_end + 1) exp_trace = {exp_trace, "."};
        exp_busy = "0";
        for (int i = 1; i < exp_end; i++) exp_busy = {exp_busy, "1"};
        exp_busy = {exp_busy, "0"};
    endtask

    task automatic run_burst(int base, int len, int restart_k);
        int widx = 0;
        obs_trace = ""; obs_busy = "";
        obs_oe.delete(); obs_valid.delete(); obs_last.delete(); obs_done.delete(); obs_data.delete();
        for (int k = 0; k <= exp_end; k++) begin
            tick();
            rd_start = (k == 0) || (k == restart_k);
            rd_base  = (k == 0) ? 18'(base) : 18'($urandom);
            rd_len   = (k == 0) ? 9'(len) : 9'd3;
            wr_valid = (k >= 1) && (widx < wq_addr.size());
            if (wr_valid) begin
                wr_addr = 18'(wq_addr[widx]);
                wr_data = wq_data[widx];
            end
            #1;
            if (wr_ready) begin
                if (mem_cs) obs_trace = {obs_trace, "W"};
                else        obs_trace = {obs_trace, "w"};
                widx++;
            end else if (mem_cs && mem_web) obs_trace = {obs_trace, "R"};
            else                            obs_trace = {obs_trace, "."};
            if (rd_busy) obs_busy = {obs_busy, "1"};
            else         obs_busy = {obs_busy, "0"};
            if (mem_oe) obs_oe.push_back(k);
            if (rd_data_valid) begin obs_valid.push_back(k); obs_data.push_back(rd_data); end
            if (rd_last) obs_last.push_back(k);
            if (rd_done) obs_done.push_back(k);
        end
        tick();
        rd_start = 1'b0;
        wr_valid = 1'b0;
    endtask

    task automatic test_burst(string name, int base, int len, int restart_k);
        bit bad;
        build_expected(base, len);
        run_burst(base, len, restart_k);
        wq_addr.delete(); wq_data.delete();
        checks++;
        if (obs_trace != exp_trace) begin
            failures++;
            $display("[TB] FAIL %s grants: got %s want %s", name, obs_trace, exp_trace);
        end
        checks++;
        if (obs_busy != exp_busy) begin
            failures++;
            $display("[TB] FAIL %s rd_busy: got %s want %s", name, obs_busy, exp_busy);
        end
        checks++;
        bad = obs_oe.size() != exp_oe.size();
        if (!bad) foreach (exp_oe[i]) if (obs_oe[i] != exp_oe[i]) bad = 1;
        if (bad) begin
            failures++;
            $display("[TB] FAIL %s mem_oe cycles: got %0d pulses want %0d", name, obs_oe.size(), exp_oe.size());
        end
        checks++;
        bad = obs_valid.size() != exp_valid.size();
        if (!bad) foreach (exp_valid[i]) if (obs_valid[i] != exp_valid[i]) bad = 1;
        if (bad) begin
            failures++;
            $display("[TB] FAIL %s valid cycles: got %0d beats want %0d", name, obs_valid.size(), exp_valid.size());
        end
        for (int i = 0; i < exp_data.size(); i++) begin
            checks++;
            if (i >= obs_data.size() || obs_data[i] !== exp_data[i]) begin
                failures++;
                $display("[TB] FAIL %s data beat %0d: got %h want %h", name, i,
                         (i < obs_data.size()) ? obs_data[i] : 16'hxxxx, exp_data[i]);
            end
        end
        checks++;
        if (obs_last.size() != 1 || obs_done.size() != 1 || obs_last[0] != exp_valid[$] || obs_done[0] != exp_valid[$]) begin
            failures++;
            $display("[TB] FAIL %s last/done: got %0d/%0d pulses want one each at cycle %0d",
                     name, obs_last.size(), obs_done.size(), exp_valid[$]);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        wr_valid = 1'b1; rd_start = 1'b1; rd_len = 9'd4; err_clr = 1'b0;
        #1;
        checks++;
        if ({wr_ready, mem_cs, mem_web, mem_oe, rd_busy, rd_data_valid, rd_last, rd_done, addr_err} !== 9'b001000000
            || mem_addr !== 18'd0 || mem_wdata !== 16'd0 || rd_data !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset values: got ctl=%b addr=%h wdata=%h rd_data=%h want ctl=001000000 zeros",
                     {wr_ready, mem_cs, mem_web, mem_oe, rd_busy, rd_data_valid, rd_last, rd_done, addr_err},
                     mem_addr, mem_wdata, rd_data);
        end
        wr_valid = 1'b0; rd_start = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        model_prefer_wr = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        do_write(32'h08000, 16'hBEEF, 1'b0);
        checks++;
        if ({w_ready, w_cs, w_web} !== 3'b110 || w_addr !== 18'h08000 || w_wdata !== 16'hBEEF) begin
            failures++;
            $display("[TB] FAIL basic write: got ready/cs/web=%b addr=%h data=%h want 110 08000 beef",
                     {w_ready, w_cs, w_web}, w_addr, w_wdata);
        end
        test_burst("basic", 32'h08000, 1, -1);
    endtask

    task automatic test_boundary();
        for (int i = 0; i < 4; i++) do_write(32'h17FFE + i, 16'(i), 1'b0);
        test_burst("boundary", 32'h17FFE, 4, -1);
    endtask

    task automatic test_contention();
        for (int i = 0; i < 4; i++) do_write(i, 16'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) begin
            wq_addr.push_back(32'h01000 + i);
            wq_data.push_back(16'($urandom));
        end
        test_burst("contention", 0, 4, -1);
        checks++;
        if (obs_trace.substr(1, 8) != "WRWRWRWR") begin
            failures++;
            $display("[TB] FAIL contention order: got %s want WRWRWRWR", obs_trace.substr(1, 8));
        end
        test_burst("contention_readback", 32'h01000, 4, -1);
    endtask

    task automatic test_oor();
        do_write(32'h30000, 16'($urandom), 1'b0);
        checks++;
        if ({w_ready, w_cs, w_err} !== 3'b101) begin
            failures++;
            $display("[TB] FAIL oor write: got ready/cs/err=%b want 101", {w_ready, w_cs, w_err});
        end
        tick(); err_clr = 1'b1; tick(); err_clr = 1'b0; #1;
        checks++;
        if (addr_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL err_clr: got addr_err=%b want 0", addr_err);
        end
        do_write(32'h3FFFF, 16'h1234, 1'b1);
        checks++;
        if (w_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL set over clear: got addr_err=%b want 1", w_err);
        end
        tick(); err_clr = 1'b1; tick(); err_clr = 1'b0; #1;
        do_write(32'h2FFFE, 16'($urandom), 1'b0);
        do_write(32'h2FFFF, 16'($urandom), 1'b0);
        checks++;
        if (w_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL in-range write flagged: got addr_err=%b want 0", w_err);
        end
        test_burst("oor_burst", 32'h2FFFE, 4, -1);
        checks++;
        if (addr_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL oor read flag: got addr_err=%b want 1", addr_err);
        end
        tick(); err_clr = 1'b1; tick(); err_clr = 1'b0; #1;
    endtask

    task automatic test_ignore();
        bit seen = 0;
        tick();
        rd_start = 1'b1; rd_len = 9'd0; rd_base = 18'h00100;
        for (int i = 0; i < 4; i++) begin
            tick();
            rd_start = 1'b0;
            #1;
            if (rd_busy || rd_done || rd_data_valid) seen = 1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("[TB] FAIL zero-length start: got busy/done/valid activity want none");
        end
        test_burst("ignore_restart", int'($urandom_range(0, 4096)), 4, 2);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rd_busy || rd_data_valid || rd_done) seen = 1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("[TB] FAIL start while busy: got extra burst activity want none");
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        tick();
        rd_start = 1'b1; rd_base = 18'h00200; rd_len = 9'd8;
        tick(); rd_start = 1'b0;
        tick(); tick();
        rstn = 1'b0; wr_valid = 1'b1; wr_addr = 18'h00300;
        #1;
        checks++;
        if ({wr_ready, mem_cs, mem_web, mem_oe, rd_busy, rd_data_valid, rd_last, rd_done, addr_err} !== 9'b001000000
            || mem_addr !== 18'd0 || mem_wdata !== 16'd0 || rd_data !== 16'd0) begin
            failures++;
            $display("[TB] FAIL mid-burst reset: got ctl=%b addr=%h wdata=%h rd_data=%h want ctl=001000000 zeros",
                     {wr_ready, mem_cs, mem_web, mem_oe, rd_busy, rd_data_valid, rd_last, rd_done, addr_err},
                     mem_addr, mem_wdata, rd_data);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rd_data_valid || rd_done || mem_cs || wr_ready) seen = 1;
        end
        rstn = 1'b1; wr_valid = 1'b0; model_prefer_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rd_data_valid || rd_done || rd_busy) seen = 1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("[TB] FAIL after reset: got leftover burst activity want none");
        end
        test_burst("post_reset", 32'h08000, 2, -1);
    endtask

    task automatic test_random();
        int base, len, nwr;
        for (int it = 0; it < 6; it++) begin
            case (it % 3)
                0: base = 32'h2FFF0 + int'($urandom_range(0, 15));
                1: base = 32'h3FFF8 + int'($urandom_range(0, 7));
                default: base = int'($urandom_range(0, DEPTH - 20));
            endcase
            len = int'($urandom_range(1, 12));
            for (int i = 0; i < len; i++)
                if ((base + i) % 262144 < DEPTH) do_write((base + i) % 262144, 16'($urandom), 1'b0);
            nwr = int'($urandom_range(0, len));
            for (int i = 0; i < nwr; i++) begin
                wq_addr.push_back(32'h20000 + it * 16 + i);
                wq_data.push_back(16'($urandom));
            end
            test_burst($sformatf("random%0d", it), base, len, -1);
            tick(); err_clr = 1'b1; tick(); err_clr = 1'b0;
        end
        test_burst("random_readback", 32'h20000, 16, -1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) sram[i] = 16'd0;
        sram_q = 16'd0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_start = 1'b0; rd_base = '0; rd_len = '0; err_clr = 1'b0;
        rstn = 1'b1;
        #2;
        test_reset();
        test_basic();
        test_boundary();
        test_contention();
        test_oor();
        test_ignore();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
